nco_wavetable_ctrl: RTL and testbench

//  Control stage directly upstream of phase2sample: phase accumulator plus wavetable-morph sweep.
//  Per sample_tick: advances oscillator phase, steps morph position across a table range.

---
 rtl/nco_pkg.sv | 27 ++
 rtl/nco_phase_acc.sv | 41 ++++
 rtl/nco_wavetable_ctrl.sv | 171 +++++++++++++++++
 tb/tb_nco_wavetable_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO / wavetable-morph control stage.
package nco_pkg;

    // Morph position is 8.8 fixed point: table index in [15:8], crossfade in [7:0].
    localparam int POS_W       = 16;
    localparam int PHASE_OUT_W = 7;

    typedef enum logic [1:0] {
        MODE_HOLD     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_LOOP     = 2'd2,
        MODE_PINGPONG = 2'd3
    } morph_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } sweep_state_t;

    // Highest table index reachable in the range; a range of 0 or 1 tables has no morph.
    function automatic logic [7:0] span_of(input logic [7:0] count);
        return (count < 8'd2) ? 8'd0 : (count - 8'd1);
    endfunction

endpackage

// File: rtl/nco_phase_acc.sv
// Free-running phase accumulator; publishes its top bits on each sample tick.
module nco_phase_acc
    import nco_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic                   clear,
    input  logic [ACC_W-1:0]       freq_inc,
    output logic [PHASE_OUT_W-1:0] phase
);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;

    // Retrigger wins over the tick so a coincident tick publishes phase 0.
    always_comb begin
        acc_next = acc_reg;
        if (clear) begin
            acc_next = '0;
        end else if (tick) begin
            acc_next = acc_reg + freq_inc;
        end
    end

    // Accumulator register; the phase output only moves on a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            phase   <= '0;
        end else begin
            acc_reg <= acc_next;
            if (tick) begin
                phase <= acc_next[ACC_W-1 -: PHASE_OUT_W];
            end
        end
    end

endmodule

// File: rtl/nco_wavetable_ctrl.sv
// Phase accumulator plus wavetable-morph sweep feeding the sample/crossfade stage.
module nco_wavetable_ctrl
    import nco_pkg::*;
#(
    parameter int ACC_W  = 24,
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_tick,
    input  logic              gate,
    input  logic [ACC_W-1:0]  freq_inc,
    input  logic [7:0]        wfm_base,
    input  logic [7:0]        wfm_count,
    input  logic [RATE_W-1:0] morph_rate,
    input  logic [1:0]        morph_mode,
    output logic              ce,
    output logic [6:0]        nco_phase,
    output logic [7:0]        wfm_num_l,
    output logic [7:0]        wfm_num_r,
    output logic [7:0]        factor,
    output logic              sweep_done
);

    logic [POS_W-1:0] rate16;
    morph_mode_t      mode;
    sweep_state_t     state_reg, state_next;
    logic [POS_W-1:0] pos_reg, pos_next;
    logic             done_reg, done_next;
    logic             gate_q_reg;
    logic             retrig;
    logic [7:0]       span;
    logic [POS_W-1:0] end_pos;
    logic [POS_W:0]   sum_up;
    logic [POS_W:0]   diff_down;
    logic             at_end;
    logic [7:0]       idx;
    logic [7:0]       idx_r;
    logic [7:0]       frac;

    // Only the low 16 bits of the rate are meaningful in 8.8 format.
    generate
        if (RATE_W >= POS_W) begin : g_rate_trim
            assign rate16 = morph_rate[POS_W-1:0];
        end else begin : g_rate_ext
            assign rate16 = {{(POS_W-RATE_W){1'b0}}, morph_rate};
        end
    endgenerate

    assign mode      = morph_mode_t'(morph_mode);
    assign retrig    = gate & ~gate_q_reg;
    assign span      = span_of(wfm_count);
    assign end_pos   = {span, 8'h00};
    assign sum_up    = {1'b0, pos_reg} + {1'b0, rate16};
    assign diff_down = {1'b0, pos_reg} - {1'b0, rate16};

    nco_phase_acc #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (sample_tick),
        .clear    (retrig),
        .freq_inc (freq_inc),
        .phase    (nco_phase)
    );

    // Sweep state, position and done flag registers; gate edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            pos_reg    <= '0;
            done_reg   <= 1'b0;
            gate_q_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pos_reg    <= pos_next;
            done_reg   <= done_next;
            gate_q_reg <= gate;
        end
    end

    // Sweep next-state: retrigger first, then gate-low idle, then per-tick stepping.
    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        done_next  = done_reg;
        if (retrig) begin
            state_next = ST_UP;
            pos_next   = '0;
            done_next  = 1'b0;
        end else if (!gate) begin
            state_next = ST_IDLE;
        end else if (sample_tick) begin
            case (state_reg)
                ST_UP: begin
                    case (mode)
                        MODE_ONESHOT: begin
                            if (sum_up >= {1'b0, end_pos}) begin
                                pos_next   = end_pos;
                                done_next  = 1'b1;
                                state_next = ST_DONE;
                            end else begin
                                pos_next = sum_up[POS_W-1:0];
                            end
                        end
                        MODE_LOOP: begin
                            if (sum_up >= {1'b0, end_pos}) begin
                                pos_next = '0;
                            end else begin
                                pos_next = sum_up[POS_W-1:0];
                            end
                        end
                        MODE_PINGPONG: begin
                            if (sum_up >= {1'b0, end_pos}) begin
                                pos_next   = end_pos;
                                state_next = ST_DOWN;
                            end else begin
                                pos_next = sum_up[POS_W-1:0];
                            end
                        end
                        default: begin
                            pos_next = pos_reg;
                        end
                    endcase
                end
                ST_DOWN: begin
                    if (mode != MODE_PINGPONG) begin
                        state_next = ST_UP;
                    end else if (diff_down[POS_W] || (diff_down[POS_W-1:0] == '0)) begin
                        pos_next   = '0;
                        state_next = ST_UP;
                    end else begin
                        pos_next = diff_down[POS_W-1:0];
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    // Table mapping of the position being published; clamps at or beyond the range end.
    always_comb begin
        at_end = (pos_next >= end_pos);
        idx    = at_end ? span  : pos_next[POS_W-1:8];
        frac   = at_end ? 8'h00 : pos_next[7:0];
        idx_r  = (idx < span) ? (idx + 8'd1) : span;
    end

    // Output registers, loaded only on a sample tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce        <= 1'b0;
            wfm_num_l <= '0;
            wfm_num_r <= '0;
            factor    <= '0;
        end else begin
            ce <= sample_tick;
            if (sample_tick) begin
                wfm_num_l <= wfm_base + idx;
                wfm_num_r <= wfm_base + idx_r;
                factor    <= frac;
            end
        end
    end

    assign sweep_done = done_reg;

endmodule

// File: tb/tb_nco_wavetable_ctrl.sv
// Self-checking bench: directed vector table, hand sequences and a randomized model run.
module tb_nco_wavetable_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sample_tick;
    logic        gate;
    logic [23:0] freq_inc;
    logic [7:0]  wfm_base;
    logic [7:0]  wfm_count;
    logic [15:0] morph_rate;
    logic [1:0]  morph_mode;
    logic        ce;
    logic [6:0]  nco_phase;
    logic [7:0]  wfm_num_l;
    logic [7:0]  wfm_num_r;
    logic [7:0]  factor;
    logic        sweep_done;

    int n_pass  = 0;
    int n_total = 0;

    nco_wavetable_ctrl #(.ACC_W(24), .RATE_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .gate        (gate),
        .freq_inc    (freq_inc),
        .wfm_base    (wfm_base),
        .wfm_count   (wfm_count),
        .morph_rate  (morph_rate),
        .morph_mode  (morph_mode),
        .ce          (ce),
        .nco_phase   (nco_phase),
        .wfm_num_l   (wfm_num_l),
        .wfm_num_r   (wfm_num_r),
        .factor      (factor),
        .sweep_done  (sweep_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural reference model ----------------
    localparam int M_IDLE = 0, M_RISING = 1, M_FALLING = 2, M_FINISHED = 3;
    int unsigned m_acc;
    int          m_pos;
    int          m_sweep;
    bit          m_done, m_gq, m_ce;
    bit [6:0]    m_ph;
    bit [7:0]    m_l, m_r, m_f;

    function automatic void model_reset();
        m_acc = 0; m_pos = 0; m_sweep = M_IDLE; m_done = 0; m_gq = 0;
        m_ce = 0; m_ph = 0; m_l = 0; m_r = 0; m_f = 0;
    endfunction

    function automatic void model_clk();
        int span, endp, p, rate, idx, ir;
        span = (int'(wfm_count) < 2) ? 0 : int'(wfm_count) - 1;
        endp = span * 256;
        rate = int'(morph_rate);
        if (gate && !m_gq) begin
            m_acc = 0; m_pos = 0; m_done = 0; m_sweep = M_RISING;
        end else begin
            if (sample_tick) m_acc = (m_acc + int'(freq_inc)) % 32'h0100_0000;
            if (!gate) begin
                m_sweep = M_IDLE;
            end else if (sample_tick && m_sweep == M_RISING) begin
                p = m_pos + rate;
                if (morph_mode == 2'd1) begin
                    if (p >= endp) begin m_pos = endp; m_done = 1; m_sweep = M_FINISHED; end
                    else m_pos = p;
                end else if (morph_mode == 2'd2) begin
                    m_pos = (p >= endp) ? 0 : p;
                end else if (morph_mode == 2'd3) begin
                    if (p >= endp) begin m_pos = endp; m_sweep = M_FALLING; end
                    else m_pos = p;
                end
            end else if (sample_tick && m_sweep == M_FALLING) begin
                if (morph_mode != 2'd3) begin
                    m_sweep = M_RISING;
                end else begin
                    p = m_pos - rate;
                    if (p <= 0) begin m_pos = 0; m_sweep = M_RISING; end
                    else m_pos = p;
                end
            end
        end
        m_gq = gate;
        m_ce = sample_tick;
        if (sample_tick) begin
            if (m_pos >= endp) begin idx = span; m_f = 8'd0; end
            else begin idx = m_pos / 256; m_f = 8'(m_pos % 256); end
            ir   = (idx + 1 > span) ? span : idx + 1;
            m_l  = 8'((int'(wfm_base) + idx) % 256);
            m_r  = 8'((int'(wfm_base) + ir) % 256);
            m_ph = 7'(m_acc >> 17);
        end
    endfunction

    function automatic logic [32:0] dut_vec();
        return {ce, nco_phase, wfm_num_l, wfm_num_r, factor, sweep_done};
    endfunction

    function automatic logic [32:0] model_vec();
        return {m_ce, m_ph, m_l, m_r, m_f, m_done};
    endfunction

    function automatic void check(string name, logic [32:0] got, logic [32:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got(ce,ph,l,r,f,done)=%h want=%h", name, got, exp);
    endfunction

    // One clock: model follows the rising edge, outputs compared at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_clk();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_tick = 0; gate = 0; freq_inc = 0; wfm_base = 0; wfm_count = 0;
        morph_rate = 0; morph_mode = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit tk; bit gt; bit [1:0] md; bit [7:0] bs; bit [7:0] cn; bit [15:0] rt; bit [23:0] fi;
        bit ece; bit [6:0] eph; bit [7:0] el; bit [7:0] er; bit [7:0] ef; bit ed;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit tk, bit gt, bit [1:0] md, bit [7:0] bs, bit [7:0] cn,
                                bit [15:0] rt, bit [23:0] fi, bit ece, bit [6:0] eph,
                                bit [7:0] el, bit [7:0] er, bit [7:0] ef, bit ed);
        vec_t v;
        v.tk = tk; v.gt = gt; v.md = md; v.bs = bs; v.cn = cn; v.rt = rt; v.fi = fi;
        v.ece = ece; v.eph = eph; v.el = el; v.er = er; v.ef = ef; v.ed = ed;
        return v;
    endfunction

    initial begin
        // ONESHOT base 10, 3 tables, rate 0.5
        tbl.push_back(mk(1,1,1,10,3,16'h80,24'h020000, 1,0,10,11,0,0));
        tbl.push_back(mk(0,1,1,10,3,16'h80,24'h020000, 0,0,10,11,0,0));
        tbl.push_back(mk(1,1,1,10,3,16'h80,24'h020000, 1,1,10,11,128,0));
        tbl.push_back(mk(1,1,1,10,3,16'h80,24'h020000, 1,2,11,12,0,0));
        tbl.push_back(mk(1,1,1,10,3,16'h80,24'h020000, 1,3,11,12,128,0));
        tbl.push_back(mk(1,1,1,10,3,16'h80,24'h020000, 1,4,12,12,0,1));
        tbl.push_back(mk(1,1,1,10,3,16'h80,24'h020000, 1,5,12,12,0,1));
        tbl.push_back(mk(0,0,1,10,3,16'h80,24'h020000, 0,5,12,12,0,1));
        tbl.push_back(mk(1,1,1,10,3,16'h80,24'h020000, 1,0,10,11,0,0));
        tbl.push_back(mk(1,1,1,10,3,16'h80,24'h020000, 1,1,10,11,128,0));
        // PINGPONG base 10, 2 tables, rate 0.25
        tbl.push_back(mk(0,0,3,10,2,16'h40,24'h0, 0,1,10,11,128,0));
        tbl.push_back(mk(1,1,3,10,2,16'h40,24'h0, 1,0,10,11,0,0));
        tbl.push_back(mk(1,1,3,10,2,16'h40,24'h0, 1,0,10,11,64,0));
        tbl.push_back(mk(1,1,3,10,2,16'h40,24'h0, 1,0,10,11,128,0));
        tbl.push_back(mk(1,1,3,10,2,16'h40,24'h0, 1,0,10,11,192,0));
        tbl.push_back(mk(1,1,3,10,2,16'h40,24'h0, 1,0,11,11,0,0));
        tbl.push_back(mk(1,1,3,10,2,16'h40,24'h0, 1,0,10,11,192,0));
        tbl.push_back(mk(1,1,3,10,2,16'h40,24'h0, 1,0,10,11,128,0));
        tbl.push_back(mk(1,1,3,10,2,16'h40,24'h0, 1,0,10,11,64,0));
        tbl.push_back(mk(1,1,3,10,2,16'h40,24'h0, 1,0,10,11,0,0));
        tbl.push_back(mk(1,1,3,10,2,16'h40,24'h0, 1,0,10,11,64,0));
        // LOOP base 0xFE, 4 tables: wrap of position and of table number
        tbl.push_back(mk(0,0,2,8'hFE,4,16'h180,24'h0, 0,0,10,11,64,0));
        tbl.push_back(mk(1,1,2,8'hFE,4,16'h180,24'h0, 1,0,8'hFE,8'hFF,0,0));
        tbl.push_back(mk(1,1,2,8'hFE,4,16'h180,24'h0, 1,0,8'hFF,8'h00,128,0));
        tbl.push_back(mk(1,1,2,8'hFE,4,16'h180,24'h0, 1,0,8'hFE,8'hFF,0,0));
        tbl.push_back(mk(1,1,2,8'hFE,4,16'h100,24'h0, 1,0,8'hFF,8'h00,0,0));
        tbl.push_back(mk(1,1,2,8'hFE,4,16'h100,24'h0, 1,0,8'h00,8'h01,0,0));
        tbl.push_back(mk(1,1,2,8'hFE,4,16'h100,24'h0, 1,0,8'hFE,8'hFF,0,0));
        // single table ONESHOT: no morph, done on the next tick
        tbl.push_back(mk(0,0,1,8'h33,1,16'h40,24'h0, 0,0,8'hFE,8'hFF,0,0));
        tbl.push_back(mk(1,1,1,8'h33,1,16'h40,24'h0, 1,0,8'h33,8'h33,0,0));
        tbl.push_back(mk(1,1,1,8'h33,1,16'h40,24'h0, 1,0,8'h33,8'h33,0,1));
        // HOLD keeps position 0
        tbl.push_back(mk(0,0,0,8'h20,3,16'h80,24'h0, 0,0,8'h33,8'h33,0,1));
        tbl.push_back(mk(1,1,0,8'h20,3,16'h80,24'h0, 1,0,8'h20,8'h21,0,0));
        tbl.push_back(mk(1,1,0,8'h20,3,16'h80,24'h0, 1,0,8'h20,8'h21,0,0));
    end

    initial begin : stim
        do_reset();
        @(negedge clk);
        check("reset_state", dut_vec(), 33'd0);

        foreach (tbl[i]) begin
            sample_tick = tbl[i].tk; gate = tbl[i].gt; morph_mode = tbl[i].md;
            wfm_base = tbl[i].bs; wfm_count = tbl[i].cn; morph_rate = tbl[i].rt;
            freq_inc = tbl[i].fi;
            cycle();
            check($sformatf("vec%0d", i), dut_vec(),
                  {tbl[i].ece, tbl[i].eph, tbl[i].el, tbl[i].er, tbl[i].ef, tbl[i].ed});
        end

        // Phase ramp: 1 step per tick, bit6 set at 64, wraps at 128
        do_reset();
        freq_inc = 24'h020000; wfm_base = 0; wfm_count = 0; morph_mode = 0;
        gate = 1; sample_tick = 1;
        for (int i = 0; i < 132; i++) begin
            cycle();
            n_total++;
            if (ce === 1'b1 && nco_phase === 7'(i % 128)) n_pass++;
            else $display("FAIL phase_ramp%0d got ce=%b ph=%0d want ce=1 ph=%0d", i, ce, nco_phase, i % 128);
        end

        // Async reset mid-sweep
        sample_tick = 0; gate = 0; cycle();
        wfm_base = 8'h40; wfm_count = 5; morph_rate = 16'h50; morph_mode = 1;
        freq_inc = 24'h031000; gate = 1;
        for (int i = 0; i < 6; i++) begin
            sample_tick = 1; cycle();
            check($sformatf("pre_reset%0d", i), dut_vec(), model_vec());
        end
        sample_tick = 0;
        #2 rst_n = 1'b0;
        #1 check("async_reset_now", dut_vec(), 33'd0);
        model_reset();
        @(negedge clk);
        check("async_reset_held", dut_vec(), 33'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check($sformatf("post_reset_idle%0d", i), dut_vec(), model_vec());
        end
        sample_tick = 1; cycle();
        check("post_reset_tick", dut_vec(), model_vec());

        // Randomized run against the model
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) begin
                morph_mode = 2'($urandom_range(0, 3));
                wfm_count  = 8'($urandom_range(0, 6));
                wfm_base   = 8'($urandom);
                case ($urandom_range(0, 5))
                    0: morph_rate = 16'h0000;
                    1: morph_rate = 16'h0020;
                    2: morph_rate = 16'h0080;
                    3: morph_rate = 16'h0100;
                    4: morph_rate = 16'h01FF;
                    default: morph_rate = 16'($urandom);
                endcase
                freq_inc = 24'($urandom);
            end
            if (i % 97 == 50) morph_mode = 2'($urandom_range(0, 3));
            sample_tick = 1'($urandom_range(0, 1));
            gate = ($urandom_range(0, 24) != 0);
            cycle();
            check($sformatf("rand%0d", i), dut_vec(), model_vec());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
